// File: rtl/keybank_poll_arbiter.sv
// keybank_poll_arbiter
//
// Shares one polled CPU read port between NUM_SRC switch-bank sources. Each
// source's enter key is sampled, and a falling edge captures that source's
// switch word into its own pending slot. A round-robin arbiter presents one
// pending slot at a time through a status/data register pair. A data read
// with ack retires the presented entry.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   data_in      switch words, source i at [i*DATA_W +: DATA_W]
//   enter_key    enter keys, idle high, a press is a falling edge
//   a0           register select: 1 = status, 0 = data
//   ack          one-cycle read strobe
//   data_out     read data (combinational from a0 and the registers)
//   pending_any  any slot pending, or an entry is being presented
//
// Status word layout (a0 = 1)
//   bit 0                      valid (an entry is presented)
//   bits [2:1]                 grant
//   bits [3+NUM_SRC-1:3]       pending vector
//   bits [8+NUM_SRC-1:8]       overflow vector (sticky, cleared by status read)
module keybank_poll_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] data_in,
    input  logic [NUM_SRC-1:0]        enter_key,
    input  logic                      a0,
    input  logic                      ack,
    output logic [DATA_W-1:0]         data_out,
    output logic                      pending_any
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t              state;
    logic [1:0]          hist [NUM_SRC];
    logic [DATA_W-1:0]   cap  [NUM_SRC];
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  ovf;
    logic [NUM_SRC-1:0]  ev;
    logic [NUM_SRC-1:0]  retire_sel;
    logic [NUM_SRC-1:0]  cap_load;
    logic [NUM_SRC-1:0]  ovf_set;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       next_grant;
    logic [GW-1:0]       scan_idx;
    logic                scan_found;
    logic                retire;
    logic                status_rd;
    logic [DATA_W-1:0]   status;

    assign retire    = (state == PRESENT) && ack && !a0;
    assign status_rd = ack && a0;

    // Per-source event decode. A press that lands in the same cycle as the
    // retire of that source refills the slot instead of overflowing it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        ev         = '0;
        retire_sel = '0;
        cap_load   = '0;
        ovf_set    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ev[i]         = (hist[i] == 2'b10);
            retire_sel[i] = retire && (grant == GW'(i));
            cap_load[i]   = ev[i] && (!pending[i] || retire_sel[i]);
            ovf_set[i]    = ev[i] && pending[i] && !retire_sel[i];
        end
    end

    // Round-robin pick: first pending slot after last_grant, with wrap.
    always_comb begin
        next_grant = last_grant;
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            scan_idx = GW'((int'(last_grant) + k) % NUM_SRC);
            if (!scan_found && pending[scan_idx]) begin
                scan_found = 1'b1;
                next_grant = scan_idx;
            end
        end
    end

    // Key history, capture slots, pending and overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the capture slots are reset too: a reset must drop any
            // entry in flight, and the slots are only a few flops wide.
            for (int i = 0; i < NUM_SRC; i++) begin
                hist[i] <= 2'b00;
                cap[i]  <= '0;
            end
            pending <= '0;
            ovf     <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                // NOTE: non-blocking assignments so every register samples the
                // pre-edge values, independent of statement order.
                hist[i] <= {hist[i][0], enter_key[i]};
                if (cap_load[i]) begin
                    pending[i] <= 1'b1;
                    cap[i]     <= data_in[i*DATA_W +: DATA_W];
                end else if (retire_sel[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            // A same-cycle overflow wins over the status-read clear.
            ovf <= (status_rd ? '0 : ovf) | ovf_set;
        end
    end

    // Presentation FSM. Reset leaves last_grant at the top source so that
    // source 0 is first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant <= next_grant;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (retire) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status                = '0;
        status[0]             = (state == PRESENT);
        status[2:1]           = 2'(grant);
        status[3 +: NUM_SRC]  = pending;
        status[8 +: NUM_SRC]  = ovf;
        if (a0) begin
            data_out = status;
        end else if (state == PRESENT) begin
            data_out = cap[grant];
        end else begin
            data_out = '0;
        end
    end

    assign pending_any = (|pending) || (state == PRESENT);

endmodule

// File: tb/tb_keybank_poll_arbiter.sv
// tb_keybank_poll_arbiter
//
// Self-checking bench for keybank_poll_arbiter (NUM_SRC = 2, DATA_W = 16).
// A behavioural model tracks keys, slots, overflow flags and the presented
// entry; every cycle data_out and pending_any are compared against it.
// Directed scenarios add fixed expected values, followed by a randomized run.
module tb_keybank_poll_arbiter;

    localparam int N = 2;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     enter_key;
    logic             a0;
    logic             ack;
    logic [W-1:0]     data_out;
    logic             pending_any;

    always #5 clk = ~clk;

    keybank_poll_arbiter #(.NUM_SRC(N), .DATA_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .enter_key   (enter_key),
        .a0          (a0),
        .ack         (ack),
        .data_out    (data_out),
        .pending_any (pending_any)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model
    bit             m_valid = 1'b0;
    bit             m_present;
    int             m_grant;
    int             m_last;
    bit             m_pend [N];
    logic [W-1:0]   m_cap  [N];
    bit             m_ovf  [N];
    bit             m_new  [N];   // most recent key sample
    bit             m_old  [N];   // sample before that

    logic [N-1:0]   r_keys;
    logic [N*W-1:0] r_din;

    function automatic logic [W-1:0] model_status();
        int s;
        s = int'(m_present) + 2 * m_grant;
        for (int i = 0; i < N; i++) begin
            s += int'(m_pend[i]) * (8 << i);
            s += int'(m_ovf[i]) * (256 << i);
        end
        return W'(s);
    endfunction

    task automatic model_step(input bit rst, input logic [N-1:0] keys,
                              input logic [N*W-1:0] din, input bit a0v, input bit ackv);
        bit old_pend [N];
        bit retire;
        bit found;
        int j;
        if (rst) begin
            m_valid   = 1'b1;
            m_present = 1'b0;
            m_grant   = 0;
            m_last    = N - 1;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_cap[i]  = '0;
                m_ovf[i]  = 1'b0;
                m_new[i]  = 1'b0;
                m_old[i]  = 1'b0;
            end
            return;
        end
        retire   = m_present && ackv && !a0v;
        old_pend = m_pend;
        if (ackv && a0v)
            for (int i = 0; i < N; i++) m_ovf[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_old[i] && !m_new[i]) begin
                if (!old_pend[i] || (retire && m_grant == i)) begin
                    m_pend[i] = 1'b1;
                    m_cap[i]  = din[i*W +: W];
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end else if (retire && m_grant == i) begin
                m_pend[i] = 1'b0;
            end
            m_old[i] = m_new[i];
            m_new[i] = keys[i];
        end
        if (!m_present) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!found && old_pend[j]) begin
                    found     = 1'b1;
                    m_grant   = j;
                    m_present = 1'b1;
                end
            end
        end else if (retire) begin
            m_present = 1'b0;
            m_last    = m_grant;
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model,
    // then advance the model to match the coming rising edge.
    task automatic cyc(input bit rst, input bit a0v, input bit ackv);
        logic [W-1:0] exp_data;
        bit           exp_any;
        @(negedge clk);
        reset     = rst;
        enter_key = r_keys;
        data_in   = r_din;
        a0        = a0v;
        ack       = ackv;
        #1;
        if (m_valid) begin
            if (a0v)            exp_data = model_status();
            else if (m_present) exp_data = m_cap[m_grant];
            else                exp_data = '0;
            exp_any = m_present;
            for (int i = 0; i < N; i++) exp_any |= m_pend[i];
            check(a0v ? "model_status" : "model_data", data_out, exp_data);
            check("model_pending_any", pending_any, exp_any);
        end
        model_step(rst, r_keys, r_din, a0v, ackv);
    endtask

    task automatic do_reset();
        r_keys = '1;
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        repeat (3) cyc(0, 1, 0);
    endtask

    task automatic release_keys();
        r_keys = '1;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
    endtask

    initial begin
        r_keys = '1;
        r_din  = '0;

        // Reset, keys idle high: nothing pending.
        do_reset();
        repeat (7) cyc(0, 1, 0);
        check("idle_status", data_out, 16'h0000);
        check("idle_pending_any", pending_any, 1'b0);

        // Single press on source 0.
        r_din[15:0] = 16'h1234;
        r_keys      = 2'b10;
        repeat (3) cyc(0, 1, 0);
        cyc(0, 1, 0);
        check("s0_status", data_out, 16'h0009);
        cyc(0, 0, 1);
        check("s0_data", data_out, 16'h1234);
        cyc(0, 1, 0);
        check("s0_retired", data_out, 16'h0000);
        release_keys();

        // Simultaneous presses after reset: source 0 first, then source 1.
        do_reset();
        r_din  = {16'h5555, 16'hAAAA};
        r_keys = 2'b00;
        repeat (3) cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("pair_first_data", data_out, 16'hAAAA);
        cyc(0, 1, 0);
        check("pair_first_status", data_out, 16'h0019);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        check("pair_gap_status", data_out, 16'h0010);
        cyc(0, 0, 1);
        check("pair_second_data", data_out, 16'h5555);
        cyc(0, 1, 0);
        check("pair_done_status", data_out, 16'h0002);
        release_keys();

        // Second press on a presented source overflows.
        r_din[31:16] = 16'h0BEE;
        r_keys       = 2'b01;
        repeat (3) cyc(0, 1, 0);
        release_keys();
        r_din[31:16] = 16'hFFFF;
        r_keys       = 2'b01;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("ovf_data_kept", data_out, 16'h0BEE);
        cyc(0, 1, 0);
        check("ovf_status", data_out, 16'h0213);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        check("ovf_cleared", data_out, 16'h0013);
        cyc(0, 0, 1);
        release_keys();

        // Retire coincides with a new press on the same source.
        r_din[15:0] = 16'h0777;
        r_keys      = 2'b10;
        repeat (3) cyc(0, 1, 0);
        release_keys();
        r_din[15:0] = 16'h0042;
        r_keys      = 2'b10;
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        check("refill_old_data", data_out, 16'h0777);
        cyc(0, 1, 0);
        check("refill_status", data_out, 16'h0008);
        cyc(0, 0, 1);
        check("refill_new_data", data_out, 16'h0042);
        cyc(0, 1, 0);
        check("refill_done", data_out, 16'h0000);
        release_keys();

        // Reset while source 1 is presented and source 0 pending.
        r_din  = {16'h6161, 16'h6060};
        r_keys = 2'b00;
        repeat (3) cyc(0, 1, 0);
        cyc(0, 1, 0);
        check("prereset_status", data_out, 16'h001B);
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        check("postreset_status", data_out, 16'h0000);
        check("postreset_pending_any", pending_any, 1'b0);
        cyc(0, 0, 0);
        check("postreset_data", data_out, 16'h0000);
        repeat (4) cyc(0, 1, 0);
        check("postreset_later_status", data_out, 16'h0000);
        release_keys();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) r_keys[i] = ~r_keys[i];
                r_din[i*W +: W] = W'($urandom);
            end
            cyc($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
